seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display that shares one hex-to-segment decoder across all digits. Each refresh slot presents one digit's nibble plus a blank flag to the shared decoder, drives the matching anode and decimal point, and inserts a guard interval against ghosting. The new display value is double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. The block sits between the system value bus and the decoder/pin outputs.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (must be greater than GUARD_CYC+1)
GUARD_CYC, 500, cycles at the start of each slot with all anodes off
LZ_SUPPRESS, 1, 1 = blank leading zero digits; digit 0 always shown

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enabled; low = display dark
value  in  4*NUM_DIGITS  display nibbles; digit i = value[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
load  in  1  single-cycle strobe; captures value/dp_in into the pending buffer
hex_out  out  4  nibble to the shared decoder
blank  out  1  1 = force all segments off (downstream gates decoder output to 7'b1111111)
an  out  NUM_DIGITS  anode enables, active-low, at most one low at any time
dp  out  1  decimal point, active-low
digit_idx  out  clog2(NUM_DIGITS)  digit currently in its slot
frame_done  out  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (async assert, sync release): an all 1, hex_out 0, blank 1, dp 1, digit_idx 0, frame_done 0, div_cnt 0, state IDLE, pending and active buffers 0, pend_valid 0.
- All outputs are registered. Segment and anode levels are active-low, consistent with the decoder's active-low segment encoding.
- Buffers: load=1 copies value/dp_in into pending and sets pend_valid. A later load before commit overwrites pending; the last load wins. When frame_done fires and pend_valid=1, pending is copied to active and pend_valid clears in the same cycle. If load and commit coincide, the load data goes to pending and pend_valid stays 1; the committed data is the old pending.
- First commit: from IDLE, the first load is committed directly to active on entry to GUARD.
- FSM states: IDLE, GUARD, SHOW.
  - IDLE: an all 1, blank 1, div_cnt 0, digit_idx 0. Moves to GUARD when enable=1.
  - GUARD: div_cnt counts up from 0. an all 1, blank 1, hex_out already set to the slot digit. Moves to SHOW when div_cnt = GUARD_CYC-1.
  - SHOW: an[digit_idx]=0, others 1. hex_out = active nibble. dp = ~active_dp[digit_idx]. blank = leading-zero flag. When div_cnt = REFRESH_DIV-1: div_cnt goes to 0, digit_idx increments (wraps NUM_DIGITS-1 -> 0), state goes to GUARD. frame_done pulses on the wrap-around cycle only.
  - enable=0 in any state: next cycle goes to IDLE with outputs dark. No partial frame_done is issued.
- Leading-zero flag (LZ_SUPPRESS=1): digit i is blanked if i>0 and active nibbles i..NUM_DIGITS-1 are all 0. dp is still driven for a blanked digit if requested. LZ_SUPPRESS=0: blank=0 during SHOW.
- Slot timing: every digit slot is exactly REFRESH_DIV cycles. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- Reset mid-frame: immediate dark outputs; pending data is lost.

Test Plan:
1. Reset and enable: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2. Load value=16'h12A9, then enable. Required sequence per digit: 2 cycles with an=4'b1111, then 6 cycles with an=1110/1101/1011/0111 in turn, hex_out=9/A/2/1. frame_done pulses once every 32 cycles. an is never low on two bits at once.
2. Frame-atomic update: load 16'h0000 mid-frame while digit 1 is shown. Required: digits 2 and 3 of the current frame still show 2 and 1. The new value appears starting at digit 0 after frame_done.
3. Leading zeros: value=16'h0070, LZ_SUPPRESS=1. Required: blank=1 for digits 3 and 2, blank=0 for digit 1 (7) and digit 0 (0). Value 16'h0000: only digit 0 is unblanked.
4. Decimal point: dp_in=4'b0100 with digit 2 a leading zero. Required: dp=0 only during digit 2's SHOW, even though blank=1 for that digit.
5. Enable drop: enable=0 during digit 2's SHOW. Required: next cycle an=1111, blank=1, digit_idx=0, no frame_done. Re-enable: the scan restarts at digit 0 with GUARD.
6. Async reset: assert rst_n=0 between clock edges during SHOW. Required: an=1111 and blank=1 immediately, without waiting for a clock edge. After release, the display stays dark until the next load and enable.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Drives one shared hex decoder and double-buffers the value so that each frame shows consistent digits.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD_CYC   = 500,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic [4*NUM_DIGITS-1:0]         value,
   input  logic [NUM_DIGITS-1:0]           dp_in,
   input  logic                            load,
   output logic [3:0]                      hex_out,
   output logic                            blank,
   output logic [NUM_DIGITS-1:0]           an,
   output logic                            dp,
   output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
   output logic                            frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYC - 1);
   localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

   state_t                  state, state_d;
   logic [CW-1:0]           cnt, cnt_d;
   logic [IW-1:0]           idx, idx_d;
   logic                    wrap, commit;
   logic [4*NUM_DIGITS-1:0] pend_val, act_val, act_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp, act_dp, act_dp_d;
   logic                    pend_valid, pend_valid_d;
   logic [3:0]              hex_d, nib;
   logic                    blank_d, dp_d, fd_d, lz_sel, dp_sel, all_zero;
   logic [NUM_DIGITS-1:0]   an_d, lz;

   // State register; outputs are registered from next-state values so they line up with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         act_val    <= '0;
         act_dp     <= '0;
         hex_out    <= 4'h0;
         blank      <= 1'b1;
         an         <= '1;
         dp         <= 1'b1;
         digit_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         idx        <= idx_d;
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         pend_valid <= pend_valid_d;
         act_val    <= act_val_d;
         act_dp     <= act_dp_d;
         hex_out    <= hex_d;
         blank      <= blank_d;
         an         <= an_d;
         dp         <= dp_d;
         digit_idx  <= idx_d;
         frame_done <= fd_d;
      end
   end

   // Next-state logic; the slot counter spans both GUARD and SHOW so every slot is REFRESH_DIV cycles.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      wrap    = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (enable) state_d = GUARD;
         end
         GUARD: begin
            cnt_d = cnt + 1'b1;
            if (cnt == G_LAST) state_d = SHOW;
         end
         SHOW: begin
            if (cnt == R_LAST) begin
               cnt_d   = '0;
               state_d = GUARD;
               if (idx == I_LAST) begin
                  idx_d = '0;
                  wrap  = 1'b1;
               end else begin
                  idx_d = idx + 1'b1;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
         wrap    = 1'b0;
      end
      // Commit only at a frame boundary or when scanning starts, using the pending data from before any coincident load.
      commit       = pend_valid && (wrap || (state == IDLE && enable));
      act_val_d    = commit ? pend_val : act_val;
      act_dp_d     = commit ? pend_dp : act_dp;
      pend_valid_d = load | (pend_valid & ~commit);
   end

   // Output logic from the next state and next active buffer.
   always_comb begin
      all_zero = 1'b1;
      lz       = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (act_val_d[4*i +: 4] == 4'h0);
         lz[i]    = all_zero & (i != 0);
      end
      nib    = 4'h0;
      lz_sel = 1'b0;
      dp_sel = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == IW'(i)) begin
            nib    = act_val_d[4*i +: 4];
            lz_sel = lz[i];
            dp_sel = act_dp_d[i];
         end
      end
      hex_d   = 4'h0;
      blank_d = 1'b1;
      an_d    = '1;
      dp_d    = 1'b1;
      fd_d    = wrap;
      case (state_d)
         GUARD: hex_d = nib;
         SHOW: begin
            hex_d   = nib;
            blank_d = (LZ_SUPPRESS != 0) ? lz_sel : 1'b0;
            dp_d    = ~dp_sel;
            for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (idx_d != IW'(i));
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: hand-computed vector table, scripted enable-drop and reset sequences,
// and randomized traffic checked against a time-since-enable reference model.
module tb_seg_scan_ctrl;

   localparam int N = 4;
   localparam int R = 8;
   localparam int G = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [15:0]   value = '0;
   logic [3:0]    dp_in = '0;
   logic          load = 1'b0;
   logic [3:0]    hex_out;
   logic          blank;
   logic [3:0]    an;
   logic          dp;
   logic [1:0]    digit_idx;
   logic          frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYC(G), .LZ_SUPPRESS(1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in), .load(load),
      .hex_out(hex_out), .blank(blank), .an(an), .dp(dp), .digit_idx(digit_idx),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: scan position derived from cycles since scanning started.
   bit          m_run = 0;
   int          m_t = 0;
   logic [15:0] m_pend = '0, m_act = '0;
   logic [3:0]  m_pdp = '0, m_adp = '0;
   bit          m_pv = 0;
   bit          m_fd = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_t = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0; m_pv = 0; m_fd = 0;
   endtask

   task automatic model_edge(input logic en, input logic ld, input logic [15:0] val, input logic [3:0] dpi);
      bit cm;
      cm   = 0;
      m_fd = 0;
      if (!en) begin
         m_run = 0;
         m_t   = 0;
      end else if (!m_run) begin
         m_run = 1;
         m_t   = 0;
         cm    = m_pv;
      end else begin
         m_t++;
         if (m_t % (N * R) == 0) begin
            m_fd = 1;
            cm   = m_pv;
         end
      end
      if (cm) begin
         m_act = m_pend;
         m_adp = m_pdp;
         m_pv  = 0;
      end
      if (ld) begin
         m_pend = val;
         m_pdp  = dpi;
         m_pv   = 1;
      end
   endtask

   task automatic compare_model();
      logic [3:0] e_an, e_hex;
      logic       e_blank, e_dp;
      int         dig, pos;
      dig = 0;
      e_an = 4'hF; e_hex = 4'h0; e_blank = 1'b1; e_dp = 1'b1;
      if (m_run) begin
         dig   = (m_t / R) % N;
         pos   = m_t % R;
         e_hex = 4'((m_act >> (4 * dig)) & 16'hF);
         if (pos >= G) begin
            e_an    = ~(4'b0001 << dig);
            e_blank = (dig > 0) && ((m_act >> (4 * dig)) == 16'h0);
            e_dp    = ~m_adp[dig];
         end
      end
      check("model_an", 32'(an), 32'(e_an));
      check("model_hex", 32'(hex_out), 32'(e_hex));
      check("model_blank", 32'(blank), 32'(e_blank));
      check("model_dp", 32'(dp), 32'(e_dp));
      check("model_idx", 32'(digit_idx), 32'(dig));
      check("model_frame_done", 32'(frame_done), 32'(m_fd));
      check("an_at_most_one_low", 32'($countones(~an) <= 1), 32'd1);
   endtask

   task automatic step(input logic en, input logic ld, input logic [15:0] val, input logic [3:0] dpi);
      enable = en; load = ld; value = val; dp_in = dpi;
      @(posedge clk);
      model_edge(en, ld, val, dpi);
      #1;
      compare_model();
   endtask

   typedef struct {
      logic        en;
      logic        ld;
      logic [15:0] val;
      logic [3:0]  dpi;
      int          cyc;
      logic [3:0]  e_an;
      logic [3:0]  e_hex;
      logic        e_blank;
      logic        e_dp;
      logic        e_fd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic en, logic ld, logic [15:0] val, logic [3:0] dpi, int cyc,
                               logic [3:0] e_an, logic [3:0] e_hex, logic e_blank, logic e_dp, logic e_fd);
      vec_t v;
      v.en = en; v.ld = ld; v.val = val; v.dpi = dpi; v.cyc = cyc;
      v.e_an = e_an; v.e_hex = e_hex; v.e_blank = e_blank; v.e_dp = e_dp; v.e_fd = e_fd;
      return v;
   endfunction

   initial begin
      // Cumulative scan time after each row is noted on the right (t = cycles since GUARD entry).
      tbl.push_back(mk(0, 1, 16'h12A9, 4'h0, 1, 4'hF, 4'h0, 1, 1, 0)); // idle, loaded
      tbl.push_back(mk(1, 0, 16'h12A9, 4'h0, 1, 4'hF, 4'h9, 1, 1, 0)); // t=0 guard d0
      tbl.push_back(mk(1, 0, 16'h12A9, 4'h0, 1, 4'hF, 4'h9, 1, 1, 0)); // t=1
      tbl.push_back(mk(1, 0, 16'h12A9, 4'h0, 1, 4'hE, 4'h9, 0, 1, 0)); // t=2 show d0
      tbl.push_back(mk(1, 0, 16'h12A9, 4'h0, 6, 4'hF, 4'hA, 1, 1, 0)); // t=8 guard d1
      tbl.push_back(mk(1, 0, 16'h12A9, 4'h0, 2, 4'hD, 4'hA, 0, 1, 0)); // t=10
      tbl.push_back(mk(1, 0, 16'h12A9, 4'h0, 8, 4'hB, 4'h2, 0, 1, 0)); // t=18
      tbl.push_back(mk(1, 0, 16'h12A9, 4'h0, 8, 4'h7, 4'h1, 0, 1, 0)); // t=26
      tbl.push_back(mk(1, 1, 16'h0070, 4'h4, 1, 4'h7, 4'h1, 0, 1, 0)); // t=27 load pending
      tbl.push_back(mk(1, 0, 16'h0070, 4'h4, 5, 4'hF, 4'h0, 1, 1, 1)); // t=32 frame_done
      tbl.push_back(mk(1, 0, 16'h0070, 4'h4, 2, 4'hE, 4'h0, 0, 1, 0)); // t=34
      tbl.push_back(mk(1, 0, 16'h0070, 4'h4, 8, 4'hD, 4'h7, 0, 1, 0)); // t=42
      tbl.push_back(mk(1, 0, 16'h0070, 4'h4, 8, 4'hB, 4'h0, 1, 0, 0)); // t=50 blank + dp
      tbl.push_back(mk(1, 0, 16'h0070, 4'h4, 8, 4'h7, 4'h0, 1, 1, 0)); // t=58
      tbl.push_back(mk(1, 0, 16'h0070, 4'h4, 6, 4'hF, 4'h0, 1, 1, 1)); // t=64
      tbl.push_back(mk(1, 0, 16'h0070, 4'h4, 10, 4'hD, 4'h7, 0, 1, 0)); // t=74
      tbl.push_back(mk(1, 1, 16'h0000, 4'h0, 1, 4'hD, 4'h7, 0, 1, 0)); // t=75 load mid-frame
      tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 7, 4'hB, 4'h0, 1, 0, 0)); // t=82 old frame kept
      tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 8, 4'h7, 4'h0, 1, 1, 0)); // t=90
      tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 8, 4'hE, 4'h0, 0, 1, 0)); // t=98 new frame
      tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 8, 4'hD, 4'h0, 1, 1, 0)); // t=106

      #12;
      check("reset_an", 32'(an), 32'hF);
      check("reset_blank", 32'(blank), 32'd1);
      check("reset_hex", 32'(hex_out), 32'h0);
      check("reset_dp", 32'(dp), 32'd1);
      check("reset_idx", 32'(digit_idx), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         for (int c = 0; c < tbl[i].cyc; c++)
            step(tbl[i].en, (c == 0) ? tbl[i].ld : 1'b0, tbl[i].val, tbl[i].dpi);
         check($sformatf("tbl%0d_an", i), 32'(an), 32'(tbl[i].e_an));
         check($sformatf("tbl%0d_hex", i), 32'(hex_out), 32'(tbl[i].e_hex));
         check($sformatf("tbl%0d_blank", i), 32'(blank), 32'(tbl[i].e_blank));
         check($sformatf("tbl%0d_dp", i), 32'(dp), 32'(tbl[i].e_dp));
         check($sformatf("tbl%0d_fd", i), 32'(frame_done), 32'(tbl[i].e_fd));
      end

      // Enable drop during digit 2's SHOW, then restart.
      for (int k = 0; k < 100 && !(m_run && ((m_t / R) % N) == 2 && (m_t % R) >= G); k++)
         step(1, 0, 16'h0, 4'h0);
      check("reach_digit2_show", 32'(digit_idx == 2 && an == 4'hB), 32'd1);
      step(0, 0, 16'h0, 4'h0);
      check("drop_an", 32'(an), 32'hF);
      check("drop_blank", 32'(blank), 32'd1);
      check("drop_idx", 32'(digit_idx), 32'd0);
      check("drop_fd", 32'(frame_done), 32'd0);
      step(1, 0, 16'h0, 4'h0);
      check("restart_guard_an", 32'(an), 32'hF);
      check("restart_guard_idx", 32'(digit_idx), 32'd0);
      step(1, 0, 16'h0, 4'h0);
      step(1, 0, 16'h0, 4'h0);
      check("restart_show_an", 32'(an), 32'hE);

      // Randomized traffic, nibbles biased towards zero to exercise leading-zero blanking.
      for (int k = 0; k < 600; k++) begin
         logic [15:0] v;
         for (int j = 0; j < 4; j++) v[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0), v, 4'($urandom));
      end

      // Asynchronous reset between edges during SHOW.
      for (int k = 0; k < 100 && !(m_run && (m_t % R) >= G); k++)
         step(1, 0, 16'h0, 4'h0);
      check("reach_show_before_reset", 32'($countones(~an)), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_reset_an", 32'(an), 32'hF);
      check("async_reset_blank", 32'(blank), 32'd1);
      check("async_reset_dp", 32'(dp), 32'd1);
      check("async_reset_idx", 32'(digit_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) step(0, 0, 16'h0, 4'h0);
      step(0, 1, 16'h4321, 4'h1);
      for (int k = 0; k < 40; k++) step(1, 0, 16'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
